// File: rtl/sub_serial_pkg.sv
// Shared definitions for the bit-serial borrow subtractor: FSM encodings,
// default width and bit-counter sizing.
package sub_serial_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam int WIDTH_DEF = 8;
   localparam int CNT_W     = $clog2(WIDTH_DEF);

   function automatic int cnt_width(input int w);
      return (w < 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor assembled from power-tagged gate cells; the borrow
// term is the adder's majority function with the minuend inverted.
module xor3_p #(
   parameter int PwrC = 0
) (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic y
);
   // PwrC only selects the accounting group; both variants are identical logic.
   if (PwrC != 0) begin : g_tagged
      assign y = a ^ b ^ c;
   end else begin : g_plain
      assign y = a ^ b ^ c;
   end
endmodule

module and2_p #(
   parameter int PwrC = 0
) (
   input  logic a,
   input  logic b,
   output logic y
);
   if (PwrC != 0) begin : g_tagged
      assign y = a & b;
   end else begin : g_plain
      assign y = a & b;
   end
endmodule

module or3_p #(
   parameter int PwrC = 0
) (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic y
);
   if (PwrC != 0) begin : g_tagged
      assign y = a | b | c;
   end else begin : g_plain
      assign y = a | b | c;
   end
endmodule

module full_subtractor_bit #(
   parameter int PwrC = 0
) (
   input  logic a,
   input  logic b,
   input  logic bi,
   output logic d,
   output logic bo
);
   logic a_n;
   logic t_ab, t_abi, t_bbi;

   assign a_n = ~a;

   xor3_p #(.PwrC(PwrC)) u_xor (.a(a),   .b(b),  .c(bi),  .y(d));
   and2_p #(.PwrC(PwrC)) u_a0  (.a(a_n), .b(b),  .y(t_ab));
   and2_p #(.PwrC(PwrC)) u_a1  (.a(a_n), .b(bi), .y(t_abi));
   and2_p #(.PwrC(PwrC)) u_a2  (.a(b),   .b(bi), .y(t_bbi));
   or3_p  #(.PwrC(PwrC)) u_or  (.a(t_ab), .b(t_abi), .c(t_bbi), .y(bo));
endmodule

// File: rtl/sub_serial_borrow.sv
// Bit-serial subtractor D = A - B - BI, LSB first, one bit per clock.
// Define SUB_OVF_EN to generate the signed-overflow flag; otherwise ovf is 0.
module sub_serial_borrow
   import sub_serial_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int PwrC  = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bi,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] d,
   output logic             bo,
   output logic             ovf
);
   localparam int CW = cnt_width(WIDTH);

   state_t           state_q;
   logic [WIDTH-1:0] ra_q, rb_q;
   logic [WIDTH-2:0] rd_q;
   logic [WIDTH-1:0] rd_d;
   logic [WIDTH-1:0] d_q;
   logic [CW-1:0]    cnt_q;
   logic             borrow_q, busy_q, done_q, bo_q;
   logic             diff_w, borrow_d;
   logic             last_bit;

   full_subtractor_bit #(.PwrC(PwrC)) u_cell (
      .a  (ra_q[0]),
      .b  (rb_q[0]),
      .bi (borrow_q),
      .d  (diff_w),
      .bo (borrow_d)
   );

   // rd holds WIDTH-1 finished bits; the final diff bit completes the word.
   assign rd_d     = {diff_w, rd_q};
   assign last_bit = (cnt_q == CW'(WIDTH - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         ra_q     <= '0;
         rb_q     <= '0;
         rd_q     <= '0;
         d_q      <= '0;
         cnt_q    <= '0;
         borrow_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         bo_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  ra_q     <= a;
                  rb_q     <= b;
                  borrow_q <= bi;
                  cnt_q    <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               ra_q     <= ra_q >> 1;
               rb_q     <= rb_q >> 1;
               rd_q     <= rd_d[WIDTH-1:1];
               borrow_q <= borrow_d;
               cnt_q    <= cnt_q + CW'(1);
               if (last_bit) begin
                  d_q     <= rd_d;
                  bo_q    <= borrow_d;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end
            end
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

`ifdef SUB_OVF_EN
   logic [1:0] sgn_q;
   logic       ovf_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sgn_q <= 2'b00;
         ovf_q <= 1'b0;
      end else begin
         if (state_q == ST_IDLE && start)
            sgn_q <= {a[WIDTH-1], b[WIDTH-1]};
         // Signs differ and the result sign departs from the minuend sign.
         if (state_q == ST_SHIFT && last_bit)
            ovf_q <= (sgn_q[1] != sgn_q[0]) && (diff_w != sgn_q[1]);
      end
   end

   assign ovf = ovf_q;
`else
   assign ovf = 1'b0;
`endif

   assign busy = busy_q;
   assign done = done_q;
   assign d    = d_q;
   assign bo   = bo_q;

endmodule

// File: tb/tb_sub_serial_borrow.sv
// Scoreboard bench for sub_serial_borrow: the driver queues expected results,
// a monitor pops and compares them on every done pulse.
module tb_sub_serial_borrow;
   localparam int W = 8;
   localparam int NV = 11;

   logic         clk = 1'b0;
   logic         reset, start, bi;
   logic [W-1:0] a, b;
   logic         busy, done, bo, ovf;
   logic [W-1:0] d;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      logic [W-1:0] d;
      logic         bo;
      logic         ovf;
      int           t0;
   } exp_t;

   exp_t         exp_q[$];
   exp_t         mon_e;
   logic [W-1:0] last_d = '0;

   sub_serial_borrow dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .a     (a),
      .b     (b),
      .bi    (bi),
      .busy  (busy),
      .done  (done),
      .d     (d),
      .bo    (bo),
      .ovf   (ovf)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: one line per completed transaction.
   always @(posedge clk) begin
      #1;
      if (reset) begin
         last_d = '0;
      end else if (done) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done actual=done required=no_done d=%0h", d);
         end else begin
            mon_e = exp_q.pop_front();
            $display("txn cycle=%0d d=%02h bo=%0b ovf=%0b exp d=%02h bo=%0b ovf=%0b",
                     cyc, d, bo, ovf, mon_e.d, mon_e.bo, mon_e.ovf);
            chk("d", 32'(d), 32'(mon_e.d));
            chk("bo", 32'(bo), 32'(mon_e.bo));
            chk("ovf", 32'(ovf), 32'(mon_e.ovf));
            chk("latency", 32'(cyc - mon_e.t0), 32'(W));
         end
         last_d = d;
      end else begin
         chk("d_stable", 32'(d), 32'(last_d));
      end
   end

   task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibi,
                         input logic [W-1:0] ed, input logic ebo, input logic eovf,
                         input int glitch_at, input int abort_at);
      int  n;
      bit  seen;
      exp_t e;
      @(negedge clk);
      a = ia; b = ib; bi = ibi; start = 1'b1;
      e.d = ed; e.bo = ebo; e.t0 = cyc + 1;
`ifdef SUB_OVF_EN
      e.ovf = eovf;
`else
      e.ovf = 1'b0;
`endif
      if (abort_at < 0) exp_q.push_back(e);
      @(negedge clk);
      start = 1'b0; a = W'($urandom); b = W'($urandom); bi = 1'b0;
      n = 0;
      seen = 0;
      while (n < 3 * W) begin
         if (done) begin
            seen = 1;
            break;
         end
         chk("busy_shift", 32'(busy), 32'd1);
         if (n == abort_at) begin
            reset = 1'b1;
            #1;
            chk("abort_busy", 32'(busy), 32'd0);
            chk("abort_done", 32'(done), 32'd0);
            chk("abort_d", 32'(d), 32'd0);
            chk("abort_bo", 32'(bo), 32'd0);
            @(negedge clk);
            reset = 1'b0;
            repeat (W + 4) @(negedge clk);
            return;
         end
         if (n == glitch_at) begin
            start = 1'b1; a = 8'hFF; b = 8'h00; bi = 1'b1;
         end
         @(negedge clk);
         start = 1'b0;
         n++;
      end
      if (!seen) begin
         checks++;
         failures++;
         $display("FAIL timeout actual=no_done required=done_within_%0d", 3 * W);
      end else begin
         @(negedge clk);
         chk("done_single", 32'(done), 32'd0);
         chk("busy_idle", 32'(busy), 32'd0);
      end
   endtask

   logic [W-1:0] va  [NV] = '{8'h5A, 8'h00, 8'h10, 8'h80, 8'h7F, 8'h05, 8'hFF, 8'h00, 8'hFF, 8'h80, 8'h3C};
   logic [W-1:0] vb  [NV] = '{8'h3C, 8'h01, 8'h0F, 8'h01, 8'hFF, 8'h03, 8'hFF, 8'h00, 8'h00, 8'h7F, 8'h5A};
   logic         vbi [NV] = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b0};
   logic [W-1:0] vd  [NV] = '{8'h1E, 8'hFF, 8'h00, 8'h7F, 8'h80, 8'h02, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'hE2};
   logic         vbo [NV] = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b1};
   logic         vov [NV] = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b0};

   initial begin
      logic [W-1:0] ra, rb;
      logic         rbi;
      logic [W:0]   r;
      reset = 1'b1; start = 1'b0; a = '0; b = '0; bi = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_d", 32'(d), 32'd0);
      chk("reset_bo", 32'(bo), 32'd0);
      chk("reset_ovf", 32'(ovf), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // start pulsed mid-operation must be ignored
      run_op(va[0], vb[0], vbi[0], vd[0], vbo[0], vov[0], 3, -1);
      // reset at SHIFT bit 4 aborts, then a fresh operation completes
      run_op(va[1], vb[1], vbi[1], vd[1], vbo[1], vov[1], -1, 4);
      for (int i = 0; i < NV; i++)
         run_op(va[i], vb[i], vbi[i], vd[i], vbo[i], vov[i], -1, -1);

      for (int i = 0; i < 100; i++) begin
         ra  = W'($urandom);
         rb  = W'($urandom);
         rbi = 1'($urandom);
         r   = {1'b0, ra} - {1'b0, rb} - {{W{1'b0}}, rbi};
         run_op(ra, rb, rbi, r[W-1:0], r[W],
                (ra[W-1] != rb[W-1]) && (r[W-1] != ra[W-1]), -1, -1);
      end

      repeat (4) @(negedge clk);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
